// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module      : rf_write_arbiter
// Description : Owns the register file write port. It merges in-order
//               writeback with buffered long-latency results and tracks
//               pending destination registers for the hazard unit.
//               Define RF_WB_BYPASS_EN to let an idle-cycle long-latency
//               result skip the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_sel,
  input  logic [DW-1:0]            wb_dat,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [AW-1:0]            lu_sel,
  input  logic [DW-1:0]            lu_dat,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_sel,
  input  logic [AW-1:0]            query_sel,
  output logic                     busy,
  output logic                     rf_WEN,
  output logic [AW-1:0]            rf_wsel,
  output logic [DW-1:0]            rf_wdat,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_NREG  = 1 << AW;
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);
  localparam logic [c_NREG-1:0]  c_R0_MASK = {{(c_NREG-1){1'b1}}, 1'b0};

  logic [DW-1:0]        r_fifo_dat [DEPTH];
  logic [AW-1:0]        r_fifo_sel [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_PTR_W:0]     r_count;
  logic [c_NREG-1:0]    r_pending;
  logic                 r_wen;
  logic [AW-1:0]        r_wsel;
  logic [DW-1:0]        r_wdat;

  logic                 w_wb_win;
  logic                 w_fifo_empty;
  logic                 w_lu_acc;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wen;
  logic [AW-1:0]        w_wsel;
  logic [DW-1:0]        w_wdat;
  logic [c_NREG-1:0]    w_set;
  logic [c_NREG-1:0]    w_clr;
  logic [c_NREG-1:0]    w_pending_nxt;

  assign lu_ready     = (r_count < c_FULL);
  assign w_wb_win     = wb_valid && (wb_sel != '0);
  assign w_fifo_empty = (r_count == '0);
  assign w_lu_acc     = lu_valid && lu_ready;
  assign w_pop        = !w_wb_win && !w_fifo_empty;

`ifdef RF_WB_BYPASS_EN
  assign w_bypass = w_lu_acc && w_fifo_empty && !w_wb_win;
`else
  assign w_bypass = 1'b0;
`endif

  // Register 0 results complete the handshake but are never stored.
  assign w_push = w_lu_acc && (lu_sel != '0) && !w_bypass;

  always_comb begin
    w_wen  = 1'b0;
    w_wsel = '0;
    w_wdat = '0;
    w_clr  = '0;
    if (w_wb_win) begin
      w_wen  = 1'b1;
      w_wsel = wb_sel;
      w_wdat = wb_dat;
    end else if (w_pop) begin
      w_wen  = 1'b1;
      w_wsel = r_fifo_sel[r_rptr];
      w_wdat = r_fifo_dat[r_rptr];
      w_clr[r_fifo_sel[r_rptr]] = 1'b1;
    end else if (w_bypass && (lu_sel != '0)) begin
      w_wen  = 1'b1;
      w_wsel = lu_sel;
      w_wdat = lu_dat;
      w_clr[lu_sel] = 1'b1;
    end
  end

  always_comb begin
    w_set = '0;
    if (issue_valid && (issue_sel != '0)) begin
      w_set[issue_sel] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  assign w_pending_nxt = ((r_pending & ~w_clr) | w_set) & c_R0_MASK;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_wen     <= 1'b0;
      r_wsel    <= '0;
      r_wdat    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_wen     <= w_wen;
      r_wsel    <= w_wsel;
      r_wdat    <= w_wdat;
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_sel[r_wptr] <= lu_sel;
      r_fifo_dat[r_wptr] <= lu_dat;
    end
  end

  assign busy = r_pending[query_sel] ||
                (issue_valid && (issue_sel == query_sel) && (query_sel != '0));

  assign rf_WEN     = r_wen;
  assign rf_wsel    = r_wsel;
  assign rf_wdat    = r_wdat;
  assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Scoreboard bench for rf_write_arbiter; expected writes are
//               queued by the stimulus and retired by a write-port monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

  logic        CLK;
  logic        nRST;
  logic        wb_valid;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_sel;
  logic [31:0] lu_dat;
  logic        issue_valid;
  logic [4:0]  issue_sel;
  logic [4:0]  query_sel;
  logic        busy;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  rf_write_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_sel(lu_sel), .lu_dat(lu_dat),
    .issue_valid(issue_valid), .issue_sel(issue_sel),
    .query_sel(query_sel), .busy(busy),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] s, input logic [31:0] d);
    wr_t e;
    e.sel = s;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_sel = '0; wb_dat = '0;
    lu_valid = 1'b0; lu_sel = '0; lu_dat = '0;
    issue_valid = 1'b0; issue_sel = '0;
  endtask

  // Every write that reaches the register file must match the next queued expectation.
  always @(negedge CLK) begin
    if (rf_WEN !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wen=%b sel=%0d dat=%h, required no write",
                 rf_WEN, rf_wsel, rf_wdat);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_WEN !== 1'b1 || rf_wsel !== mon_e.sel || rf_wdat !== mon_e.dat) begin
          errors++;
          $display("FAIL write_port: got sel=%0d dat=%h, required sel=%0d dat=%h",
                   rf_wsel, rf_wdat, mon_e.sel, mon_e.dat);
        end
      end
    end
  end

  initial begin
    idle();
    query_sel = '0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_wen",   32'(rf_WEN), 32'd0);
    chk("reset_wsel",  32'(rf_wsel), 32'd0);
    chk("reset_wdat",  rf_wdat, 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ready", 32'(lu_ready), 32'd1);
    nRST = 1'b1;
    tick();

    // Plain writeback, then an idle cycle.
    wb_valid = 1'b1; wb_sel = 5'd5; wb_dat = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    chk("wb_idle_wen", 32'(rf_WEN), 32'd0);

    // One buffered entry drained through a dropped wb_sel==0 slot.
    wb_valid = 1'b1; wb_sel = 5'd1; wb_dat = 32'h11;
    lu_valid = 1'b1; lu_sel = 5'd7; lu_dat = 32'h77;
    expect_wr(5'd1, 32'h11);
    tick();
    idle();
    wb_valid = 1'b1; wb_sel = 5'd0; wb_dat = 32'h1234;
    expect_wr(5'd7, 32'h77);
    #1;
    chk("one_entry_count", 32'(fifo_count), 32'd1);
    tick();
    idle();
    #1;
    chk("drained_count", 32'(fifo_count), 32'd0);
    tick();

    // Fill the FIFO behind continuous writeback, then drain in order.
    for (int i = 0; i < 6; i++) begin
      wb_valid = 1'b1; wb_sel = 5'(10 + i); wb_dat = 32'hA000 + 32'(i);
      expect_wr(5'(10 + i), 32'hA000 + 32'(i));
      if (i < 4) begin
        lu_valid = 1'b1; lu_sel = 5'(16 + i); lu_dat = 32'h100 + 32'(i);
      end else if (i == 4) begin
        lu_valid = 1'b1; lu_sel = 5'd20; lu_dat = 32'hBAD;
      end else begin
        lu_valid = 1'b0;
      end
      #1;
      chk("fill_count", 32'(fifo_count), (i < 4) ? 32'(i) : 32'd4);
      chk("fill_ready", 32'(lu_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      expect_wr(5'(16 + j), 32'h100 + 32'(j));
      #1;
      chk("drain_count", 32'(fifo_count), 32'(4 - j));
      tick();
    end
    chk("drain_empty", 32'(fifo_count), 32'd0);
    tick();

    // Scoreboard: same-cycle busy, clear on retire, set-wins on re-issue.
    issue_valid = 1'b1; issue_sel = 5'd9; query_sel = 5'd9;
    #1;
    chk("busy_same_cycle", 32'(busy), 32'd1);
    tick();
    idle();
    wb_valid = 1'b1; wb_sel = 5'd2; wb_dat = 32'h22;
    lu_valid = 1'b1; lu_sel = 5'd9; lu_dat = 32'h99;
    expect_wr(5'd2, 32'h22);
    #1;
    chk("busy_registered", 32'(busy), 32'd1);
    tick();
    idle();
    expect_wr(5'd9, 32'h99);
    #1;
    chk("busy_in_pop_cycle", 32'(busy), 32'd1);
    tick();
    chk("busy_after_pop", 32'(busy), 32'd0);
    issue_valid = 1'b1; issue_sel = 5'd9;
    tick();
    idle();
    wb_valid = 1'b1; wb_sel = 5'd2; wb_dat = 32'h23;
    lu_valid = 1'b1; lu_sel = 5'd9; lu_dat = 32'h9A;
    expect_wr(5'd2, 32'h23);
    tick();
    idle();
    issue_valid = 1'b1; issue_sel = 5'd9;
    expect_wr(5'd9, 32'h9A);
    tick();
    idle();
    #1;
    chk("busy_reissue_wins", 32'(busy), 32'd1);
    issue_valid = 1'b1; issue_sel = 5'd0; query_sel = 5'd0;
    #1;
    chk("busy_reg0", 32'(busy), 32'd0);
    tick();
    idle();

    // Reset with three buffered entries and pending[3] set.
    for (int k = 0; k < 3; k++) begin
      issue_valid = (k == 0); issue_sel = 5'd3;
      wb_valid = 1'b1; wb_sel = 5'(12 + k); wb_dat = 32'hC000 + 32'(k);
      lu_valid = 1'b1; lu_sel = 5'(3 + k); lu_dat = 32'hE000 + 32'(k);
      expect_wr(5'(12 + k), 32'hC000 + 32'(k));
      tick();
    end
    idle();
    wb_valid = 1'b1; wb_sel = 5'd11; wb_dat = 32'hC0DE;
    expect_wr(5'd11, 32'hC0DE);
    query_sel = 5'd3;
    #1;
    chk("pre_reset_count", 32'(fifo_count), 32'd3);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    tick();
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    idle();
    #1;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_wen", 32'(rf_WEN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    tick();
    nRST = 1'b1;
    repeat (3) tick();
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    // Discarded register-0 long-latency result.
    lu_valid = 1'b1; lu_sel = 5'd0; lu_dat = 32'hF0;
    tick();
    idle();
    chk("lu_sel0_count", 32'(fifo_count), 32'd0);
    repeat (2) tick();

    // Idle-cycle long-latency latency.
    lu_valid = 1'b1; lu_sel = 5'd4; lu_dat = 32'hA5;
    expect_wr(5'd4, 32'hA5);
    tick();
    idle();
`ifdef RF_WB_BYPASS_EN
    chk("lu_lat_n1", 32'(rf_WEN), 32'd1);
    tick();
    chk("lu_lat_n2", 32'(rf_WEN), 32'd0);
`else
    chk("lu_lat_n1", 32'(rf_WEN), 32'd0);
    tick();
    chk("lu_lat_n2", 32'(rf_WEN), 32'd1);
`endif
    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
